// File: rtl/riscv_mc_ctrl_if.sv
// riscv_mc_ctrl_if: control bundle between the multicycle main FSM and its datapath.
interface riscv_mc_ctrl_if;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       illegal_instr;
  logic [3:0] state;
  modport master (
    input  op, zero, mem_ready,
    output pc_write, ir_write, adr_src, mem_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, illegal_instr, state
  );
  modport slave (
    output op, zero, mem_ready,
    input  pc_write, ir_write, adr_src, mem_write, reg_write, result_src,
           alu_src_a, alu_src_b, alu_op, illegal_instr, state
  );
endinterface

// File: rtl/riscv_mc_ctrl_fsm.sv
// riscv_mc_ctrl_fsm: multicycle RISC-V main control FSM, Moore decode with mem_ready stall.
module riscv_mc_ctrl_fsm #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input logic clk,
  input logic resetn,
  riscv_mc_ctrl_if.master bus
);
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, ALUWB, EXECI, JAL, BEQ
  } state_t;
  state_t st, nxt;
  logic rdy, legal;
  always_comb begin
    rdy = MEM_WAIT_EN ? bus.mem_ready : 1'b1;
    legal = bus.op inside {OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};
    nxt = FETCH;
    case (st)
      FETCH:    nxt = rdy ? DECODE : FETCH;
      DECODE:   nxt = (bus.op == OP_LW || bus.op == OP_SW) ? MEMADR :
                      bus.op == OP_R   ? EXECR :
                      bus.op == OP_I   ? EXECI :
                      bus.op == OP_JAL ? JAL :
                      bus.op == OP_BEQ ? BEQ : FETCH;
      MEMADR:   nxt = bus.op == OP_LW ? MEMREAD : MEMWRITE;
      MEMREAD:  nxt = rdy ? MEMWB : MEMREAD;
      MEMWRITE: nxt = rdy ? FETCH : MEMWRITE;
      EXECR, EXECI, JAL: nxt = ALUWB;
      default:  nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk)
    st <= !resetn ? FETCH : nxt;
  // Everything except the debug state is forced low while reset is held
  always_comb begin
    bus.state         = st;
    bus.pc_write      = resetn && ((st == FETCH && rdy) || st == JAL || (st == BEQ && bus.zero));
    bus.ir_write      = resetn && st == FETCH && rdy;
    bus.adr_src       = resetn && (st == MEMREAD || st == MEMWRITE);
    bus.mem_write     = resetn && st == MEMWRITE;
    bus.reg_write     = resetn && (st == MEMWB || st == ALUWB);
    bus.illegal_instr = resetn && st == DECODE && !legal;
    bus.result_src    = !resetn ? 2'b00 : st == FETCH ? 2'b10 : st == MEMWB ? 2'b01 : 2'b00;
    bus.alu_src_a     = !resetn ? 2'b00 :
                        (st == DECODE || st == JAL) ? 2'b01 :
                        (st == MEMADR || st == EXECR || st == EXECI || st == BEQ) ? 2'b10 : 2'b00;
    bus.alu_src_b     = !resetn ? 2'b00 :
                        (st == FETCH || st == JAL) ? 2'b10 :
                        (st == DECODE || st == MEMADR || st == EXECI) ? 2'b01 : 2'b00;
    bus.alu_op        = !resetn ? 2'b00 :
                        (st == EXECR || st == EXECI) ? 2'b10 : st == BEQ ? 2'b01 : 2'b00;
  end
endmodule

// File: tb/tb_riscv_mc_ctrl_fsm.sv
// tb_riscv_mc_ctrl_fsm: directed sequence bench for the multicycle control FSM.
module tb_riscv_mc_ctrl_fsm;
  logic clk = 1'b0;
  logic resetn;
  int checks = 0;
  int failures = 0;
  riscv_mc_ctrl_if bus();
  riscv_mc_ctrl_fsm dut (.clk(clk), .resetn(resetn), .bus(bus));
  always #5 clk = ~clk;
  logic [17:0] obs;
  assign obs = {bus.state, bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write,
                bus.illegal_instr, bus.adr_src, bus.result_src, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op};
  // expected control word for a given state, straight from the per-state settings table
  function automatic logic [17:0] ev(input logic [3:0] s, input logic mr, input logic z,
                                     input logic rn, input logic [6:0] op);
    logic pc, ir, mw, rw, il, ad;
    logic [1:0] rs, a, b, ao;
    {pc, ir, mw, rw, il, ad, rs, a, b, ao} = '0;
    case (s)
      4'd0:  begin pc = mr; ir = mr; b = 2'b10; rs = 2'b10; end
      4'd1:  begin a = 2'b01; b = 2'b01;
               il = !(op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                      op == 7'b0010011 || op == 7'b1101111 || op == 7'b1100011); end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  ad = 1'b1;
      4'd4:  begin rs = 2'b01; rw = 1'b1; end
      4'd5:  begin ad = 1'b1; mw = 1'b1; end
      4'd6:  begin a = 2'b10; ao = 2'b10; end
      4'd7:  rw = 1'b1;
      4'd8:  begin a = 2'b10; b = 2'b01; ao = 2'b10; end
      4'd9:  begin a = 2'b01; b = 2'b10; pc = 1'b1; end
      4'd10: begin a = 2'b10; ao = 2'b01; pc = z; end
      default: ;
    endcase
    return rn ? {s, pc, ir, mw, rw, il, ad, rs, a, b, ao} : {s, 14'b0};
  endfunction
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic test_reset();
    resetn = 1'b0; bus.mem_ready = 1'b1; bus.op = 7'b0110011; bus.zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      #1;
      if (obs !== ev(4'd0, 1'b1, 1'b0, 1'b0, bus.op)) begin
        failures++; $display("FAIL reset cyc%0d got %h exp %h", i, obs, ev(4'd0, 1'b1, 1'b0, 1'b0, bus.op));
      end
      checks++;
    end
    resetn = 1'b1;
    #1;
    if (bus.ir_write !== 1'b1 || bus.pc_write !== 1'b1 || bus.state !== 4'd0) begin
      failures++; $display("FAIL reset_release got ir=%b pc=%b st=%0d exp ir=1 pc=1 st=0", bus.ir_write, bus.pc_write, bus.state);
    end
    checks++;
  endtask
  task automatic test_rtype();
    int s[5] = '{0, 1, 6, 7, 0};
    bus.op = 7'b0110011; bus.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (obs !== ev(4'(s[i]), 1'b1, bus.zero, 1'b1, bus.op)) begin
        failures++; $display("FAIL rtype cyc%0d got %h exp %h", i, obs, ev(4'(s[i]), 1'b1, bus.zero, 1'b1, bus.op));
      end
      checks++;
      if (i < 4) cyc();
    end
  endtask
  task automatic test_itype_jal();
    int si[5] = '{0, 1, 8, 7, 0};
    int sj[5] = '{0, 1, 9, 7, 0};
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.op = k == 0 ? 7'b0010011 : 7'b1101111;
      for (int i = 0; i < 5; i++) begin
        #1;
        if (obs !== ev(4'(k == 0 ? si[i] : sj[i]), 1'b1, bus.zero, 1'b1, bus.op)) begin
          failures++; $display("FAIL %s cyc%0d got %h exp %h", k == 0 ? "itype" : "jal", i, obs,
                               ev(4'(k == 0 ? si[i] : sj[i]), 1'b1, bus.zero, 1'b1, bus.op));
        end
        checks++;
        if (i < 4) cyc();
      end
    end
  endtask
  task automatic test_lw_wait();
    int s[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
    bit mr[9] = '{1, 1, 0, 0, 0, 0, 1, 1, 1};
    bus.op = 7'b0000011;
    for (int i = 0; i < 9; i++) begin
      bus.mem_ready = mr[i];
      #1;
      if (obs !== ev(4'(s[i]), mr[i], bus.zero, 1'b1, bus.op)) begin
        failures++; $display("FAIL lw cyc%0d got %h exp %h", i, obs, ev(4'(s[i]), mr[i], bus.zero, 1'b1, bus.op));
      end
      checks++;
      if (s[i] == 4 && bus.result_src !== 2'b01) begin
        failures++; $display("FAIL lw_result_src got %b exp 01", bus.result_src);
      end
      if (s[i] == 4) checks++;
      if (i < 8) cyc();
    end
  endtask
  task automatic test_sw_wait();
    int s[7] = '{0, 0, 1, 2, 5, 5, 0};
    bit mr[7] = '{0, 1, 1, 1, 0, 1, 1};
    bus.op = 7'b0100011;
    for (int i = 0; i < 7; i++) begin
      bus.mem_ready = mr[i];
      #1;
      if (obs !== ev(4'(s[i]), mr[i], bus.zero, 1'b1, bus.op)) begin
        failures++; $display("FAIL sw cyc%0d got %h exp %h", i, obs, ev(4'(s[i]), mr[i], bus.zero, 1'b1, bus.op));
      end
      checks++;
      if (i < 6) cyc();
    end
  endtask
  task automatic test_beq();
    int s[4] = '{0, 1, 10, 0};
    bus.op = 7'b1100011; bus.mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.zero = k == 0;
      for (int i = 0; i < 4; i++) begin
        #1;
        if (obs !== ev(4'(s[i]), 1'b1, bus.zero, 1'b1, bus.op)) begin
          failures++; $display("FAIL beq_z%0d cyc%0d got %h exp %h", bus.zero, i, obs, ev(4'(s[i]), 1'b1, bus.zero, 1'b1, bus.op));
        end
        checks++;
        if (s[i] == 10 && bus.pc_write !== bus.zero) begin
          failures++; $display("FAIL beq_pc_write got %b exp %b", bus.pc_write, bus.zero);
        end
        if (s[i] == 10) checks++;
        if (i < 3) cyc();
      end
    end
    bus.zero = 1'b0;
  endtask
  task automatic test_illegal();
    int s[3] = '{0, 1, 0};
    bus.op = 7'b1111111; bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (obs !== ev(4'(s[i]), 1'b1, bus.zero, 1'b1, bus.op)) begin
        failures++; $display("FAIL illegal cyc%0d got %h exp %h", i, obs, ev(4'(s[i]), 1'b1, bus.zero, 1'b1, bus.op));
      end
      checks++;
      if (i == 1 && bus.illegal_instr !== 1'b1) begin
        failures++; $display("FAIL illegal_pulse got %b exp 1", bus.illegal_instr);
      end
      if (i == 1) checks++;
      if (i < 2) cyc();
    end
  endtask
  task automatic test_reset_mid();
    bus.op = 7'b0110011; bus.mem_ready = 1'b1;
    repeat (3) cyc();
    resetn = 1'b0;
    #1;
    if (obs !== ev(4'd7, 1'b1, 1'b0, 1'b0, bus.op)) begin
      failures++; $display("FAIL reset_mid_s7 got %h exp %h", obs, ev(4'd7, 1'b1, 1'b0, 1'b0, bus.op));
    end
    checks++;
    cyc();
    #1;
    if (obs !== ev(4'd0, 1'b1, 1'b0, 1'b0, bus.op)) begin
      failures++; $display("FAIL reset_mid_next got %h exp %h", obs, ev(4'd0, 1'b1, 1'b0, 1'b0, bus.op));
    end
    checks++;
    resetn = 1'b1;
    #1;
    if (obs !== ev(4'd0, 1'b1, 1'b0, 1'b1, bus.op)) begin
      failures++; $display("FAIL reset_mid_release got %h exp %h", obs, ev(4'd0, 1'b1, 1'b0, 1'b1, bus.op));
    end
    checks++;
  endtask
  initial begin
    test_reset();
    test_rtype();
    test_itype_jal();
    test_lw_wait();
    test_sw_wait();
    test_beq();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_mc_ctrl_fsm.md
Name: riscv_mc_ctrl_fsm

Overview:
Main control state machine of the multicycle RISC-V core. It generates the register-enable strobes (PC write, instruction-register write) and the datapath mux/ALU selects consumed by the enable-flop registers (CurrPC, OldPC, Instr) and the ALU/result muxes. It sequences one instruction through Fetch/Decode/Execute/Mem/Writeback, stalling on a memory-ready handshake.

Parameters:
MEM_WAIT_EN, 1, 1: mem_ready is honoured; 0: mem_ready is internally forced to 1.

Ports:
clk  in  1  system clock, all state updates on rising edge
resetn  in  1  synchronous active-low reset
op  in  7  opcode field of the instruction register (Instr[6:0])
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  enable for the CurrPC register
ir_write  out  1  enable for the Instr and OldPC registers
adr_src  out  1  0 = PC, 1 = ALU result register
mem_write  out  1  data memory write strobe
reg_write  out  1  register-file write enable
result_src  out  2  00 = ALUOut, 01 = read data, 10 = ALU result
alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1 data
alu_src_b  out  2  00 = rs2 data, 01 = immediate, 10 = constant 4
alu_op  out  2  00 = add, 01 = subtract/branch, 10 = funct-decoded
illegal_instr  out  1  one-cycle pulse in Decode on an unsupported opcode
state  out  4  current state encoding (debug)

Behaviour:
- Clock and reset: reset is synchronous and active-low. On a rising clk edge with resetn==0, state <= FETCH (0).
- Outputs during reset: while resetn==0, all strobes (pc_write, ir_write, mem_write, reg_write, illegal_instr) are forced to 0. All selects are 0.
- State encoding:
  - FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5
  - EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10
  - Codes 11-15 are unreachable. If reached, the next state is FETCH.
- Outputs are decoded from state (Moore), except for the mem_ready gating in FETCH and the zero term in pc_write.
- Per-state settings (unlisted signals are 0):
  - FETCH: adr_src=0, alu_src_b=10, result_src=10, alu_op=00. ir_write=mem_ready; pc_update=mem_ready.
  - DECODE: alu_src_a=01, alu_src_b=01, alu_op=00.
  - MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00.
  - MEMREAD: adr_src=1, result_src=00.
  - MEMWB: result_src=01, reg_write=1.
  - MEMWRITE: adr_src=1, mem_write=1.
  - EXECR: alu_src_a=10, alu_src_b=00, alu_op=10.
  - EXECI: alu_src_a=10, alu_src_b=01, alu_op=10.
  - ALUWB: result_src=00, reg_write=1.
  - JAL: alu_src_a=01, alu_src_b=10, result_src=00, pc_update=1.
  - BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, branch=1.
- PC write: pc_write = pc_update | (branch & zero).
- Transitions:
  - FETCH -> DECODE when mem_ready; otherwise hold.
  - DECODE dispatches on op:
    - 0000011 (lw) or 0100011 (sw) -> MEMADR
    - 0110011 -> EXECR
    - 0010011 -> EXECI
    - 1101111 -> JAL
    - 1100011 -> BEQ
    - any other op -> FETCH, with illegal_instr=1 for that cycle
  - MEMADR -> MEMREAD if op==0000011, else MEMWRITE.
  - MEMREAD -> MEMWB when mem_ready; otherwise hold.
  - MEMWRITE -> FETCH when mem_ready; otherwise hold, with mem_write kept asserted.
  - MEMWB -> FETCH.
  - EXECR -> ALUWB; EXECI -> ALUWB; JAL -> ALUWB.
  - ALUWB -> FETCH; BEQ -> FETCH.
- Cycles per instruction with zero wait states:
  - lw = 5
  - sw = 4
  - R-type = 4
  - I-type = 4
  - jal = 4
  - beq = 3
  - illegal = 2
- Each wait cycle on mem_ready adds 1 cycle.
- Reset mid-instruction: on the next edge state is FETCH, and no strobe fires in the reset cycle.
- mem_ready is ignored in all states other than FETCH, MEMREAD and MEMWRITE.

Test Plan:
- Reset: assert resetn=0 for 2 cycles with mem_ready=1 -> all strobes 0, state=0; first cycle after release ir_write=1, pc_write=1.
- R-type with mem_ready held 1 (op=0110011) -> state sequence 0,1,6,7,0; reg_write=1 only in state 7; pc_write=1 only in state 0.
- lw with mem_ready low for 3 cycles in MEMREAD (op=0000011) -> sequence 0,1,2,3,3,3,3,4,0; result_src=01 in state 4.
- sw with mem_ready low for 1 cycle in FETCH (op=0100011) -> FETCH held 2 cycles, ir_write=0 then 1; mem_write=1 for exactly the cycles in state 5.
- beq (op=1100011): zero=1 -> pc_write=1 in state 10; zero=0 -> pc_write=0 in state 10; both return to 0.
- Illegal op=1111111 -> illegal_instr pulses 1 cycle in DECODE, next state 0, no reg_write or mem_write; resetn=0 asserted in state 7 -> reg_write=0 in that cycle, state=0 next.
